count_xfer_sched: RTL and testbench

Two-requester round-robin scheduler that sequences the shared counter/converter datapath. A granted requester's length is latched, and the block then performs four steps: clear the counter, enable it for exactly that many clocks, enable the converter output, and hand the result off with a Valid/Ready handshake. It sits beside the counter/converter pair and drives their CountEnable, CountReset and OutEnable controls.

---
 rtl/count_xfer_sched_if.sv | 28 ++
 rtl/count_xfer_sched.sv | 151 +++++++++++++++
 tb/tb_count_xfer_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_xfer_sched_if.sv
// Request/control bundle between the requesters, the scheduler and the
// counter/converter pair. The master modport is the requester side.
interface count_xfer_sched_if #(
   parameter int unsigned p_hi = 7
);
   logic [1:0]    req;
   logic [p_hi:0] len0;
   logic [p_hi:0] len1;
   logic          ready;
   logic [1:0]    grant;
   logic [1:0]    ack;
   logic          valid;
   logic          count_enable;
   logic          count_reset;
   logic          out_enable;
   logic          busy;
   logic          error;

   modport master (
      output req, len0, len1, ready,
      input  grant, ack, valid, count_enable, count_reset, out_enable, busy, error
   );

   modport slave (
      input  req, len0, len1, ready,
      output grant, ack, valid, count_enable, count_reset, out_enable, busy, error
   );
endinterface

// File: rtl/count_xfer_sched.sv
// Two-requester round-robin scheduler for the shared counter/converter
// datapath: clear the counter, count for the latched length, enable the
// converter output and hand the result off with valid/ready.
// Optional build macro SCHED_TIMEOUT_EN: abandon a transfer whose ready does
// not arrive within p_timeout cycles and pulse error instead of ack.
module count_xfer_sched #(
   parameter int unsigned p_hi      = 7,
   parameter int unsigned p_timeout = 15
) (
   input logic               clk,
   input logic               rst,
   count_xfer_sched_if.slave bus
);
   localparam int unsigned LW = p_hi + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_XFER  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [LW-1:0] len_r, len_nxt;
   logic [LW-1:0] tally, tally_nxt;
   logic          last_r, last_nxt;
   logic [1:0]    elig;
   logic          pick;
   logic [1:0]    grant_nxt, ack_nxt;
   logic          valid_nxt, cen_nxt, crst_nxt, oen_nxt, busy_nxt, err_nxt;

`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned WW = (p_timeout > 1) ? $clog2(p_timeout) : 1;
   logic [WW-1:0] wcnt, wcnt_nxt;
`else
   // p_timeout only matters when the timeout is built in
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(p_timeout);
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         len_r  <= '0;
         tally  <= '0;
         last_r <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
         wcnt   <= '0;
`endif
      end else begin
         state  <= state_nxt;
         len_r  <= len_nxt;
         tally  <= tally_nxt;
         last_r <= last_nxt;
`ifdef SCHED_TIMEOUT_EN
         wcnt   <= wcnt_nxt;
`endif
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.grant        <= '0;
         bus.ack          <= '0;
         bus.valid        <= 1'b0;
         bus.count_enable <= 1'b0;
         bus.count_reset  <= 1'b0;
         bus.out_enable   <= 1'b0;
         bus.busy         <= 1'b0;
         bus.error        <= 1'b0;
      end else begin
         bus.grant        <= grant_nxt;
         bus.ack          <= ack_nxt;
         bus.valid        <= valid_nxt;
         bus.count_enable <= cen_nxt;
         bus.count_reset  <= crst_nxt;
         bus.out_enable   <= oen_nxt;
         bus.busy         <= busy_nxt;
         bus.error        <= err_nxt;
      end
   end

   // Arbitration: the requester just acked sits out one cycle; ties go to
   // whoever was not served last
   assign elig = bus.req & ~bus.ack;
   assign pick = (elig == 2'b11) ? ~last_r : elig[1];

   // Next state, datapath updates and next output values
   always_comb begin
      state_nxt = state;
      len_nxt   = len_r;
      tally_nxt = tally;
      last_nxt  = last_r;
      grant_nxt = bus.grant;
      ack_nxt   = 2'b00;
      err_nxt   = 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wcnt_nxt  = '0;
`endif

      unique case (state)
         S_IDLE: begin
            if (elig != 2'b00) begin
               grant_nxt = pick ? 2'b10 : 2'b01;
               len_nxt   = pick ? bus.len1 : bus.len0;
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            tally_nxt = '0;
            state_nxt = (len_r != '0) ? S_RUN : S_XFER;
         end
         S_RUN: begin
            tally_nxt = tally + LW'(1);
            if (tally == len_r - LW'(1)) begin
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            if (bus.ready) begin
               ack_nxt   = bus.grant;
               last_nxt  = bus.grant[1];
               grant_nxt = 2'b00;
               state_nxt = S_IDLE;
            end
`ifdef SCHED_TIMEOUT_EN
            else if (wcnt == WW'(p_timeout - 1)) begin
               err_nxt   = 1'b1;
               last_nxt  = bus.grant[1];
               grant_nxt = 2'b00;
               state_nxt = S_IDLE;
            end else begin
               wcnt_nxt  = wcnt + WW'(1);
            end
`endif
         end
         default: begin
            state_nxt = S_IDLE;
            grant_nxt = 2'b00;
         end
      endcase

      crst_nxt  = (state_nxt == S_CLEAR);
      cen_nxt   = (state_nxt == S_RUN);
      valid_nxt = (state_nxt == S_XFER);
      oen_nxt   = (state_nxt == S_XFER);
      busy_nxt  = (state_nxt != S_IDLE);
   end
endmodule

// File: tb/tb_count_xfer_sched.sv
// Bench for count_xfer_sched: directed phases plus random traffic, checked
// every cycle against a transaction-timeline model (offset from grant).
module tb_count_xfer_sched;
   localparam int unsigned HI = 7;
   localparam int unsigned LW = HI + 1;
`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 15;
`endif

   logic clk;
   logic rst;

   count_xfer_sched_if #(.p_hi(HI)) bus ();

   count_xfer_sched #(.p_hi(HI), .p_timeout(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   // Reference model: one transaction described by owner, length and the
   // cycle offset since grant
   logic       m_busy;
   logic       m_last;
   logic       own;
   int         m_d;
   int         m_len;
`ifdef SCHED_TIMEOUT_EN
   int         m_wait;
`endif
   logic [1:0] e_grant, e_ack;
   logic       e_valid, e_cen, e_crst, e_oen, e_busy, e_err;
   int         cnt_m;

   // Stimulus knobs
   int         req_mode;    // 0 random, 1 only r0, 2 both, 3 only r1
   int         ready_mode;  // 0 random, 1 high, 2 low
   logic       fix_len;
   logic [HI:0] f_len0, f_len1;
   logic       rst_arm;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_last  = 1'b1;
      own     = 1'b0;
      m_d     = 0;
      m_len   = 0;
`ifdef SCHED_TIMEOUT_EN
      m_wait  = 0;
`endif
      e_grant = 2'b00;
      e_ack   = 2'b00;
      e_valid = 1'b0;
      e_cen   = 1'b0;
      e_crst  = 1'b0;
      e_oen   = 1'b0;
      e_busy  = 1'b0;
      e_err   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs set for the next edge
   task automatic model_step();
      logic [1:0] elig;
      logic [1:0] n_ack;
      logic       n_err;
      logic       accept;
      logic       expire;
      n_ack = 2'b00;
      n_err = 1'b0;
      if (!m_busy) begin
         elig = bus.req & ~e_ack;
         if (elig != 2'b00) begin
            own    = (elig == 2'b11) ? ~m_last : elig[1];
            m_len  = int'(own ? bus.len1 : bus.len0);
            m_d    = 0;
            m_busy = 1'b1;
`ifdef SCHED_TIMEOUT_EN
            m_wait = 0;
`endif
         end
      end else begin
         accept = e_valid && bus.ready;
         expire = 1'b0;
`ifdef SCHED_TIMEOUT_EN
         expire = e_valid && !bus.ready && (m_wait + 1 == int'(TO));
         if (e_valid) m_wait++;
`endif
         if (accept || expire) begin
            m_busy = 1'b0;
            m_last = own;
            if (accept) n_ack = own ? 2'b10 : 2'b01;
            else        n_err = 1'b1;
         end else begin
            m_d++;
         end
      end
      e_ack   = n_ack;
      e_err   = n_err;
      e_busy  = m_busy;
      e_grant = m_busy ? (own ? 2'b10 : 2'b01) : 2'b00;
      e_crst  = m_busy && (m_d == 0);
      e_cen   = m_busy && (m_d >= 1) && (m_d <= m_len);
      e_valid = m_busy && (m_d > m_len);
      e_oen   = e_valid;
   endtask

   task automatic compare_outs();
      check("grant", 32'(bus.grant), 32'(e_grant));
      check("ack", 32'(bus.ack), 32'(e_ack));
      check("valid", 32'(bus.valid), 32'(e_valid));
      check("count_enable", 32'(bus.count_enable), 32'(e_cen));
      check("count_reset", 32'(bus.count_reset), 32'(e_crst));
      check("out_enable", 32'(bus.out_enable), 32'(e_oen));
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("error", 32'(bus.error), 32'(e_err));
      check("exclusive", 32'($countones({bus.count_enable, bus.count_reset, bus.out_enable}) <= 1), 32'(1));
      if (e_valid) check("counter", 32'(cnt_m), 32'(m_len));
   endtask

   task automatic gen_inputs();
      logic [1:0] r;
      r = bus.req;
      case (req_mode)
         1: r = 2'b01;
         2: r = 2'b11;
         3: r = 2'b10;
         default: begin
            for (int i = 0; i < 2; i++) begin
               if (r[i]) begin
                  if (e_ack[i] && $urandom_range(1, 0) == 0) r[i] = 1'b0;
                  else if (m_busy && (own == 1'(i)) && $urandom_range(15, 0) == 0) r[i] = 1'b0;
               end else if ($urandom_range(3, 0) == 0) begin
                  r[i] = 1'b1;
               end
            end
         end
      endcase
      bus.req = r;
      if (fix_len) begin
         bus.len0 = f_len0;
         bus.len1 = f_len1;
      end else begin
         bus.len0 = ($urandom_range(15, 0) == 0) ? LW'($urandom) : LW'($urandom_range(6, 0));
         bus.len1 = ($urandom_range(15, 0) == 0) ? LW'($urandom) : LW'($urandom_range(6, 0));
      end
      case (ready_mode)
         1:       bus.ready = 1'b1;
         2:       bus.ready = 1'b0;
         default: bus.ready = ($urandom_range(2, 0) != 0);
      endcase
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         if (rst_arm && m_busy && (m_d == 3)) begin
            rst_arm = 1'b0;
            rst = 1'b1;
            #1;
            model_reset();
            compare_outs();
            @(negedge clk);
            rst = 1'b0;
         end
         compare_outs();
         if (bus.count_reset) cnt_m = 0;
         else if (bus.count_enable) cnt_m++;
         gen_inputs();
         model_step();
         @(negedge clk);
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      bus.req = 2'b00;
      bus.len0 = '0;
      bus.len1 = '0;
      bus.ready = 1'b0;
      n_checks = 0;
      n_errors = 0;
      cnt_m = 0;
      req_mode = 0;
      ready_mode = 0;
      fix_len = 1'b0;
      f_len0 = '0;
      f_len1 = '0;
      rst_arm = 1'b0;
      model_reset();

      @(negedge clk);
      compare_outs();
      @(negedge clk);
      rst = 1'b0;

      // single requester, length 5
      req_mode = 1; ready_mode = 1; fix_len = 1'b1; f_len0 = LW'(5); f_len1 = LW'(1);
      run_cycles(20);
      // both held: alternating grants, lengths 2 and 3
      req_mode = 2; f_len0 = LW'(2); f_len1 = LW'(3);
      run_cycles(40);
      // zero length goes straight to transfer
      req_mode = 3; f_len1 = LW'(0);
      run_cycles(10);
      // consumer stalls with ready low
      req_mode = 1; f_len0 = LW'(3); ready_mode = 2;
      run_cycles(18);
      ready_mode = 1;
      run_cycles(12);
      // reset during the count phase, then a full redo
      f_len0 = LW'(8); rst_arm = 1'b1;
      run_cycles(40);
      // longest length, no wrap
      f_len0 = '1;
      run_cycles(300);
      // random traffic
      req_mode = 0; ready_mode = 0; fix_len = 1'b0;
      run_cycles(4000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
